// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host receiver.
package ps2_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

endpackage

// File: rtl/ps2_edge_filter.sv
// Input conditioning for the PS/2 lines: synchronises ps2_clk and ps2_dat,
// debounces the clock over FILTER_LEN samples and strobes its falling edge.
// SYNC_STAGES must be at least 2.
module ps2_edge_filter
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic dat_sync_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic [CW-1:0]          run_q;
  logic                   filt_q;
  logic                   filt_prev_q;
  logic                   clk_sync;

  assign clk_sync   = clk_sync_q[SYNC_STAGES-1];
  assign dat_sync_o = dat_sync_q[SYNC_STAGES-1];

  // Synchroniser chains; they reset to the idle level so reset release is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      dat_sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
    end
  end

  // Debounce: the filtered clock follows only after FILTER_LEN differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= '0;
      filt_q      <= IDLE_LEVEL;
      filt_prev_q <= IDLE_LEVEL;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_sync != filt_q) begin
        if (run_q == CW'(FILTER_LEN - 1)) begin
          filt_q <= clk_sync;
          run_q  <= '0;
        end else begin
          run_q <= run_q + 1'b1;
        end
      end else begin
        run_q <= '0;
      end
    end
  end

  assign fall_o = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises start/8 data/odd parity/stop
// frames and presents bytes on a ready/valid interface.
// Optional macro PS2_RX_TIMEOUT_EN adds an abort of stalled partial frames.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ps2_rx: TIMEOUT_CYCLES must be at least 2");
  end

  state_e               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 fall;
  logic                 dat_bit;
  logic                 tmo;

  ps2_edge_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_dat_i  (ps2_dat),
    .dat_sync_o (dat_bit),
    .fall_o     (fall)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  // Clocks since the last fall; the abort pulse lands TIMEOUT_CYCLES after that fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        to_cnt_q <= '0;
    else if (state_q == IDLE || fall)  to_cnt_q <= '0;
    else                               to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign tmo = (state_q != IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 2));
`else
  assign tmo = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      par_q      <= 1'b1;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // Frame FSM: advances on the filtered falling edge, or aborts on timeout.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (tmo) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          // A high level here is a glitch, not a start bit.
          if (!dat_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_d     = 1'b1;
          end
        end
        DATA: begin
          shreg_d[bit_cnt_q] = dat_bit;
          par_d              = par_q ^ dat_bit;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
          else                                bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: begin
          par_d   = par_q ^ dat_bit;
          state_d = STOP;
        end
        STOP: begin
          // Odd parity leaves par at 0 once all nine bits are folded in.
          if (!dat_bit)                       ferr_d = 1'b1;
          else if (par_q)                     perr_d = 1'b1;
          else if (rx_valid_q && !rx_ready)   ovr_d  = 1'b1;
          else begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: a device model drives frames, expected bytes
// and pulses are queued, and a negedge monitor pops and compares them.
module tb_ps2_rx;

  localparam int SYNC = 2;
  localparam int FLT  = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 40;
  localparam int LAT  = SYNC + FLT + 1;

  typedef enum int {EV_PERR = 1, EV_FERR = 2, EV_OVR = 3} ev_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_bytes[$];
  ev_e        exp_ev[$];
  int         mon_n;
  ev_e        mon_ev;

  ps2_rx #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b);
    ps2_dat = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  // Full frame; lat = clocks from driving the stop-bit fall to the first response.
  task automatic send_frame(logic [7:0] d, logic flip_par, logic stop_bit, output int lat);
    logic v0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ flip_par);
    ps2_dat = stop_bit;
    tick(HALF);
    v0 = rx_valid;
    ps2_clk = 1'b0;
    lat = -1;
    for (int k = 1; k <= HALF; k++) begin
      tick(1);
      if (lat < 0 && ((rx_valid && !v0) || parity_err || frame_err || overrun)) lat = k;
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(2 * HALF);
  endtask

  // Start bit plus nbits data bits; returns right after the last bit's fall is driven.
  task automatic send_partial(logic [7:0] d, int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits - 1; i++) send_bit(d[i]);
    ps2_dat = d[nbits-1];
    tick(HALF);
    ps2_clk = 1'b0;
  endtask

  // Monitor: handshakes pop expected bytes, pulses pop expected events.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        if (exp_bytes.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %02h, required no byte", rx_data);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_bytes.pop_front()});
        end
      end
      if (parity_err || frame_err || overrun) begin
        mon_n = int'(parity_err) + int'(frame_err) + int'(overrun);
        check("pulse_exclusive", mon_n, 1);
        mon_ev = parity_err ? EV_PERR : (frame_err ? EV_FERR : EV_OVR);
        if (exp_ev.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got kind %0d, required none", int'(mon_ev));
        end else begin
          check("pulse_kind", mon_ev, exp_ev.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t;
    logic bad;

    tick(5);
    check("reset_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 0);
    rst_n = 1'b1;
    tick(10);
    check("post_reset_busy_valid", {rx_valid, busy}, 0);

    for (int i = 0; i < 16; i++) begin
      exp_bytes.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b1, lat);
      check("valid_latency", lat, LAT);
    end

    exp_ev.push_back(EV_PERR);
    send_frame(8'hA5, 1'b1, 1'b1, lat);
    check("perr_latency", lat, LAT);
    check("perr_no_valid", rx_valid, 0);
    exp_bytes.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, lat);
    check("after_perr_latency", lat, LAT);

    exp_ev.push_back(EV_FERR);
    send_frame(8'h81, 1'b0, 1'b0, lat);
    check("ferr_latency", lat, LAT);
    check("ferr_no_valid", rx_valid, 0);

    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy) bad = 1'b1;
      tick(1);
    end
    check("glitch_busy", bad, 0);

    rx_ready = 1'b0;
    exp_bytes.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b1, lat);
    check("hold_latency", lat, LAT);
    exp_ev.push_back(EV_OVR);
    send_frame(8'h22, 1'b0, 1'b1, lat);
    check("overrun_latency", lat, LAT);
    check("held_data", {24'd0, rx_data}, 32'h11);
    check("held_valid", rx_valid, 1);
    rx_ready = 1'b1;
    tick(1);
    check("valid_after_accept", rx_valid, 0);

    send_partial(8'hFF, 4);
    tick(HALF);
    check("busy_mid_frame", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(5);
    check("reset_held_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 0);
    rst_n = 1'b1;
    tick(10);
    exp_bytes.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, lat);
    check("after_reset_latency", lat, LAT);

`ifdef PS2_RX_TIMEOUT_EN
    exp_ev.push_back(EV_FERR);
    send_partial(8'h07, 3);
    t = -1;
    for (int k = 1; k <= TMO + LAT + 50 && t < 0; k++) begin
      tick(1);
      if (frame_err) t = k;
    end
    check("timeout_delay", t, SYNC + FLT + TMO);
    ps2_clk = 1'b1;
    tick(HALF);
    check("timeout_busy", busy, 0);
    check("timeout_no_valid", rx_valid, 0);
    exp_bytes.push_back(8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1, lat);
    check("after_timeout_latency", lat, LAT);
`endif

    tick(20);
    check("bytes_outstanding", exp_bytes.size(), 0);
    check("events_outstanding", exp_ev.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Host-side receiver for the device-to-host PS/2-style serial link.
- The device drives one frame per byte: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- Device changes dat while clk is high; the host samples on each falling edge of clk.
- Block synchronises and filters the external clk/dat lines, deserialises frames, checks them, and presents bytes on a ready/valid interface to the scan-code logic.

Parameters:
- SYNC_STAGES, 2, flop stages on ps2_clk and ps2_dat before any use.
- FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered ps2_clk changes.
- TIMEOUT_CYCLES, 2000, system clocks without a filtered falling edge before a partial frame is aborted (used only when PS2_RX_TIMEOUT_EN is defined).

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  external serial clock, asynchronous, idles high.
- ps2_dat  input  1  external serial data, asynchronous, idles high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts the byte when rx_valid&&rx_ready.
- parity_err  output  1  one-cycle pulse: frame had bad parity.
- frame_err  output  1  one-cycle pulse: stop bit was 0, or a timeout abort occurred.
- overrun  output  1  one-cycle pulse: a good frame completed while rx_valid=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async on rst_n low): state=IDLE; rx_data=0; rx_valid=0; all pulses=0; busy=0.
  - Sync/filter flops reset to 1, so the filtered clock resets to 1 and no spurious edge occurs at reset release.
- Input conditioning:
  - Filtered clock toggles only after FILTER_LEN identical synchronised samples.
  - fall = filtered 1->0, one-cycle strobe.
  - Data is sampled from the synchronised ps2_dat in the cycle fall is high.
- State machine (advances only on fall, except timeout):
  - IDLE: bit=0 -> DATA, cnt=0, par=1. Bit=1 is ignored (glitch), state stays IDLE.
  - DATA: shift the bit into shreg[cnt] (LSB first); par ^= bit; after cnt==7 -> PARITY.
  - PARITY: par ^= bit; -> STOP.
  - STOP, evaluated in priority order:
    - stop bit=0 -> frame_err pulse.
    - else par!=0 -> parity_err pulse.
    - else if rx_valid=1 and not being accepted this cycle -> overrun pulse; new byte dropped; rx_data unchanged.
    - else rx_data<=shreg and rx_valid<=1.
    - All four cases -> IDLE.
- Latency: rx_valid rises exactly 1 clk after the fall strobe of the stop bit. Pulses occur in that same cycle.
- Handshake:
  - rx_valid clears the cycle after rx_valid&&rx_ready.
  - Accept and new-byte completion in the same cycle: the new byte loads, rx_valid stays 1, no overrun.
- Odd parity check: XOR of 8 data bits and the parity bit must equal 1.
- Error and overrun pulses are mutually exclusive per frame.
- busy=0 only in IDLE.
- rst_n asserted mid-frame discards the partial frame. The next start bit after release is received normally.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - A counter counts clks while state!=IDLE and clears on every fall.
  - Reaching TIMEOUT_CYCLES gives state->IDLE plus a frame_err pulse. No rx_valid results from the aborted frame.
- Undefined:
  - No counter is instantiated.
  - A stalled partial frame stays in its state until further edges arrive.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, DATA, PARITY, STOP).
  - DATA_BITS=8.
  - IDLE_LEVEL=1'b1.
- Sub-module ps2_edge_filter:
  - Synchroniser plus FILTER_LEN debounce plus falling-edge strobe.
  - Instantiated once for ps2_clk.
  - Also exports the synchronised dat.

Test Plan:
- Device model (40-clk half periods, dat changes while high) sends bytes 0x00..0x0F with rx_ready=1 -> 16 rx_valid handshakes with rx_data 0x00..0x0F in order; no error or overrun pulses.
- Send 0xA5 with the parity bit inverted -> one parity_err pulse; rx_valid stays 0; next frame 0x3C received correctly.
- Send 0x81 with stop bit 0 -> one frame_err pulse; no rx_valid. A 2-clk low glitch on ps2_clk while idle -> no state change, busy stays 0.
- rx_ready=0; send 0x11 then 0x22 -> rx_data=0x11 held with rx_valid=1; one overrun pulse at the end of the 0x22 frame; after accept, rx_valid=0.
- Assert rst_n low after 4 data bits of 0xFF, release, then send 0x5A -> all outputs 0 during reset; 0x5A received with no errors.
- With PS2_RX_TIMEOUT_EN defined: stop clocking after 3 data bits -> frame_err exactly TIMEOUT_CYCLES clks after the last fall; busy=0; following frame 0xE0 received correctly.
